spi_tx_frame_engine: RTL and testbench
======================================

Name: spi_tx_frame_engine

Overview:
- Read-side consumer of the AHB-to-SPI TX FIFO (41-bit command words). Runs entirely in the SPI clock domain.
- Pops one word per transaction and serialises it as an SPI mode-0 master frame.
- For read commands, captures the 32-bit MISO response and pushes it into the RX FIFO toward the AHB side.

Parameters:
- CLK_DIV, 4, SCLK half-period in rd_clk cycles (legal range ≥1).
- CS_SETUP, 2, rd_clk cycles from cs_n falling to the first SCLK rising edge (≥1).
- CS_HOLD, 2, rd_clk cycles from the last SCLK falling edge to cs_n rising (≥1).

Ports:
- rd_clk  input  1  SPI-domain clock.
- rd_rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new frames to start; the current frame always completes.
- tx_empty  input  1  TX FIFO empty flag.
- tx_rd_en  output  1  TX FIFO pop strobe; the FIFO presents tx_rd_data one cycle later.
- tx_rd_data  input  41  command word: [40]=1 write / 0 read, [39:32] addr, [31:0] wdata.
- rx_full  input  1  RX FIFO full flag.
- rx_wr_en  output  1  RX FIFO push strobe.
- rx_wr_data  output  40  read response {addr[7:0], rdata[31:0]}.
- sclk  output  1  SPI clock, CPOL=0.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in; synchronised externally.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous on rd_rst_n low, including mid-frame): state=IDLE, sclk=0, cs_n=1, mosi=0, tx_rd_en=0, rx_wr_en=0, rx_wr_data=0, busy=0, all counters 0. An aborted frame is discarded; no RX push occurs.
- States: IDLE → POP → LOAD → SETUP → SHIFT → HOLD → [RESP] → IDLE.
- IDLE: if enable && !tx_empty, drive tx_rd_en=1 for exactly one cycle and go to POP. Otherwise stay in IDLE.
- POP: wait one cycle for FIFO read data, then go to LOAD.
- LOAD: latch tx_rd_data into a 41-bit shift register.
  - cs_n falls at the end of this cycle.
  - mosi = bit 40.
  - Go to SETUP.
- SETUP: hold for CS_SETUP cycles with sclk=0, then go to SHIFT.
- SHIFT: toggle sclk every CLK_DIV cycles; 41 rising and 41 falling edges in total.
  - On each rising transition, sample miso into the response shift register. Only the last 32 rising edges (data phase) are kept.
  - On each falling transition except the 41st, shift the shift register left and update mosi to the next bit.
  - For read commands, mosi=0 throughout the data phase regardless of [31:0].
  - After the 41st falling edge, go to HOLD.
- HOLD: after CS_HOLD cycles, cs_n=1 and mosi=0.
  - Read command → RESP.
  - Write command → IDLE.
- RESP: when !rx_full, pulse rx_wr_en for one cycle with rx_wr_data={addr, captured rdata}, then go to IDLE.
  - If rx_full is high, stall in RESP indefinitely. Responses are never dropped.
  - cs_n stays high while stalled.
- Frame timing: cs_n low for exactly CS_SETUP + 82·CLK_DIV + CS_HOLD cycles.
- Inter-frame gap: minimum 3 rd_clk cycles of cs_n high (IDLE, POP, LOAD). Back-to-back frames run with no other gap.
- enable dropping mid-frame has no effect until the frame returns to IDLE.
- tx_rd_en is never asserted while tx_empty=1.
- rx_wr_en is never asserted while rx_full=1.
- Bit counter: 6 bits, counts 0..40, no wrap. Divider counter: width clog2(CLK_DIV) + 1.

Decomposition:
- Shared package spi_bridge_pkg holds:
  - CMD_W=41, ADDR_W=8, DATA_W=32.
  - Field positions: CMD_BIT=40, ADDR_MSB=39, ADDR_LSB=32.
  - The state enumeration.
  - RSP_W=40.
- One sub-module, spi_sclk_gen: divider counter plus sclk register, producing single-cycle rise_pulse/fall_pulse strobes. Inputs are run and CLK_DIV.

Test Plan:
- Write 41'h1_5A_DEADBEEF, CLK_DIV=4 → cs_n low 332 cycles; mosi bits 1, 0x5A, 0xDEADBEEF MSB first, sampled on sclk rise; exactly 41 rises; no rx_wr_en.
- Read 41'h0_3C_00000000 with slave model returning 0x12345678 → mosi data phase all 0; single rx_wr_en with rx_wr_data=40'h3C_12345678.
- Two writes queued back-to-back → two frames separated by exactly 3 cycles of cs_n high; tx_rd_en pulses twice, one cycle each.
- Read with rx_full held high for 50 cycles after HOLD → busy=1, cs_n=1, no push; push occurs the first cycle after rx_full falls, data intact.
- rd_rst_n asserted at rise #20 of a read → same cycle sclk=0, cs_n=1, mosi=0, busy=0; no RX push; the next queued word runs as a clean frame.
- tx_empty=1 or enable=0 for 100 cycles → tx_rd_en never asserts, cs_n=1; enable cleared mid-frame → frame completes, then no further pops.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared widths, field positions and FSM states for the
// SPI side of the AHB-to-SPI bridge.
package spi_bridge_pkg;

  localparam int CMD_W    = 41;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int RSP_W    = 40;
  localparam int CMD_BIT  = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_RESP
  } state_t;

  // Read frames drive zeros through the data phase.
  function automatic logic [CMD_W-1:0] mosi_image(
    input logic [CMD_W-1:0] cmd
  );
    return cmd[CMD_BIT] ? cmd
         : {cmd[CMD_BIT:ADDR_LSB], {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_tx_frame_engine_if.sv
// FIFO and SPI pin bundle for the TX frame engine.
// master = engine side, slave = FIFOs / pads / bench side.
interface spi_tx_frame_engine_if;
  import spi_bridge_pkg::*;

  logic             enable;
  logic             tx_empty;
  logic             tx_rd_en;
  logic [CMD_W-1:0] tx_rd_data;
  logic             rx_full;
  logic             rx_wr_en;
  logic [RSP_W-1:0] rx_wr_data;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             busy;

  modport master (
    input  enable, tx_empty, tx_rd_data,
    input  rx_full, miso,
    output tx_rd_en, rx_wr_en, rx_wr_data,
    output sclk, cs_n, mosi, busy
  );

  modport slave (
    output enable, tx_empty, tx_rd_data,
    output rx_full, miso,
    input  tx_rd_en, rx_wr_en, rx_wr_data,
    input  sclk, cs_n, mosi, busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while run is high.
// rise/fall strobes flag the rd_clk edge on which sclk changes.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick     = run && (r_cnt == LAST);
  assign rise_pulse = w_tick && !r_sclk;
  assign fall_pulse = w_tick && r_sclk;
  assign sclk       = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_frame_engine.sv
// Pops TX command words, runs one SPI mode-0 frame per word
// and pushes read responses into the RX FIFO.
module spi_tx_frame_engine
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input logic rd_clk,
  input logic rd_rst_n,
  spi_tx_frame_engine_if.master bus
);

  localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);
  localparam logic [5:0]    LAST_BIT   = 6'd40;

  state_t            r_state;
  logic [CMD_W-1:0]  r_sr;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_wr;
  logic [5:0]        r_bit_cnt;
  logic [PW-1:0]     r_ph_cnt;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_tx_rd_en;
  logic              r_rx_wr_en;
  logic [RSP_W-1:0]  r_rx_wr_data;
  logic              w_sclk;
  logic              w_rise;
  logic              w_fall;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk        (rd_clk),
    .rst_n      (rd_rst_n),
    .run        (r_state == S_SHIFT),
    .sclk       (w_sclk),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  assign bus.sclk       = w_sclk;
  assign bus.cs_n       = r_cs_n;
  assign bus.mosi       = r_sr[CMD_W-1];
  assign bus.busy       = r_busy;
  assign bus.tx_rd_en   = r_tx_rd_en;
  assign bus.rx_wr_en   = r_rx_wr_en;
  assign bus.rx_wr_data = r_rx_wr_data;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_rdata      <= '0;
      r_addr       <= '0;
      r_is_wr      <= 1'b0;
      r_bit_cnt    <= '0;
      r_ph_cnt     <= '0;
      r_cs_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_tx_rd_en   <= 1'b0;
      r_rx_wr_en   <= 1'b0;
      r_rx_wr_data <= '0;
    end else begin
      r_tx_rd_en <= 1'b0;
      r_rx_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.enable && !bus.tx_empty) begin
            r_tx_rd_en <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_POP;
          end
        end
        S_POP: r_state <= S_LOAD;
        S_LOAD: begin
          r_sr      <= mosi_image(bus.tx_rd_data);
          r_addr    <= bus.tx_rd_data[ADDR_MSB:ADDR_LSB];
          r_is_wr   <= bus.tx_rd_data[CMD_BIT];
          r_cs_n    <= 1'b0;
          r_bit_cnt <= '0;
          r_ph_cnt  <= '0;
          r_state   <= S_SETUP;
        end
        S_SETUP: begin
          if (r_ph_cnt == SETUP_LAST) begin
            r_ph_cnt <= '0;
            r_state  <= S_SHIFT;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          // 32-bit shift keeps only the data-phase samples
          if (w_rise) r_rdata <= {r_rdata[DATA_W-2:0], bus.miso};
          if (w_fall) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= S_HOLD;
            end else begin
              r_sr      <= r_sr << 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_ph_cnt == HOLD_LAST) begin
            r_ph_cnt <= '0;
            r_cs_n   <= 1'b1;
            r_sr     <= '0;
            if (r_is_wr) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RESP;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (!bus.rx_full) begin
            r_rx_wr_en   <= 1'b1;
            r_rx_wr_data <= {r_addr, r_rdata};
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_frame_engine.sv
// Scoreboard bench: stimulus queues expected frames/responses,
// negedge monitors pop and compare as the engine produces them.
module tb_spi_tx_frame_engine;

  typedef struct {
    logic [40:0] bits;
    int          gap;
  } frm_t;

  logic rd_clk = 1'b0;
  logic rd_rst_n = 1'b1;
  always #5 rd_clk = ~rd_clk;

  spi_tx_frame_engine_if bus ();

  spi_tx_frame_engine #(
    .CLK_DIV  (4),
    .CS_SETUP (2),
    .CS_HOLD  (2)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  int pops = 0;

  frm_t        exp_frm[$];
  logic [39:0] exp_rsp[$];
  logic [40:0] txq[$];
  logic [40:0] pop_w;
  logic [40:0] s_pat = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_tx(input logic [40:0] w);
    txq.push_back(w);
    bus.tx_empty <= 1'b0;
  endtask

  task automatic exp_frame(input logic [40:0] b, input int g);
    frm_t f;
    f.bits = b;
    f.gap = g;
    exp_frm.push_back(f);
  endtask

  // TX FIFO model: data appears the cycle after the pop strobe
  always @(posedge rd_clk) begin
    if (bus.tx_rd_en && txq.size() != 0) begin
      pop_w = txq.pop_front();
      bus.tx_rd_data <= pop_w;
      bus.tx_empty <= (txq.size() == 0);
    end
  end

  // SPI slave: first bit before rise 1, advance after each fall
  int   s_fcnt = 0;
  logic s_psclk = 1'b0;
  always @(negedge rd_clk) begin
    if (bus.cs_n) s_fcnt = 0;
    else if (s_psclk && !bus.sclk && s_fcnt < 40) s_fcnt++;
    s_psclk = bus.sclk;
    bus.miso = bus.cs_n ? 1'b0 : s_pat[40 - s_fcnt];
  end

  // frame monitor
  logic        m_in = 1'b0;
  logic        m_pcs = 1'b1;
  logic        m_psclk = 1'b0;
  logic [40:0] m_bits = '0;
  int          m_rises = 0;
  int          m_low = 0;
  int          m_gap = 0;
  int          m_gap_seen = 0;
  frm_t        m_f;
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      m_in = 1'b0;
      m_gap = 0;
      m_pcs = 1'b1;
      m_psclk = 1'b0;
    end else begin
      if (m_pcs && !bus.cs_n) begin
        m_in = 1'b1;
        m_bits = '0;
        m_rises = 0;
        m_low = 0;
        m_gap_seen = m_gap;
      end
      if (!bus.cs_n) begin
        m_low++;
        if (!m_psclk && bus.sclk) begin
          m_bits = {m_bits[39:0], bus.mosi};
          m_rises++;
        end
      end else begin
        if (!m_pcs && m_in) begin
          m_in = 1'b0;
          total++;
          if (exp_frm.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame mosi=%0h", m_bits);
          end else begin
            m_f = exp_frm.pop_front();
            chk("frame_mosi", m_bits, m_f.bits);
            chk("frame_rises", m_rises, 41);
            chk("frame_cs_low", m_low, 332);
            if (m_f.gap >= 0) chk("frame_gap", m_gap_seen, m_f.gap);
          end
          m_gap = 0;
        end
        m_gap++;
      end
      m_pcs = bus.cs_n;
      m_psclk = bus.sclk;
    end
  end

  // RX push and TX pop monitors
  logic m_prev_rd = 1'b0;
  always @(negedge rd_clk) begin
    if (rd_rst_n && bus.rx_wr_en) begin
      chk("rx_full_at_push", bus.rx_full, 1'b0);
      total++;
      if (exp_rsp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rx_push data=%0h", bus.rx_wr_data);
      end else begin
        chk("rx_data", bus.rx_wr_data, exp_rsp.pop_front());
      end
    end
    if (bus.tx_rd_en) begin
      pops++;
      chk("pop_not_empty", bus.tx_empty, 1'b0);
      chk("pop_single", m_prev_rd, 1'b0);
    end
    m_prev_rd = bus.tx_rd_en;
  end

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    @(negedge rd_clk);
    while ((txq.size() != 0 || bus.busy) && c < 5000) begin
      @(negedge rd_clk);
      c++;
    end
    if (c >= 5000) begin
      total++;
      bad++;
      $display("FAIL %s timeout busy=%0b", nm, bus.busy);
    end
    repeat (4) @(negedge rd_clk);
  endtask

  task automatic wait_cs(input logic lvl, input string nm);
    int c;
    c = 0;
    while (bus.cs_n !== lvl && c < 3000) begin
      @(negedge rd_clk);
      c++;
    end
    if (c >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s timeout cs_n=%0b want=%0b", nm, bus.cs_n, lvl);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int p0;
    int rises;
    int c;
    logic ps;
    bus.enable = 1'b0;
    bus.rx_full = 1'b0;
    bus.miso = 1'b0;
    bus.tx_empty <= 1'b1;
    bus.tx_rd_data <= '0;
    #3 rd_rst_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_sclk", bus.sclk, 1'b0);
    chk("rst_cs_n", bus.cs_n, 1'b1);
    chk("rst_mosi", bus.mosi, 1'b0);
    chk("rst_tx_rd_en", bus.tx_rd_en, 1'b0);
    chk("rst_rx_wr_en", bus.rx_wr_en, 1'b0);
    chk("rst_rx_wr_data", bus.rx_wr_data, 40'h0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;

    // write frame
    exp_frame(41'h1_5A_DEADBEEF, -1);
    push_tx(41'h1_5A_DEADBEEF);
    bus.enable = 1'b1;
    wait_idle("write");

    // read frame, wdata must not reach mosi
    s_pat = {9'h1FF, 32'h12345678};
    exp_frame(41'h0_3C_00000000, -1);
    exp_rsp.push_back(40'h3C_12345678);
    push_tx(41'h0_3C_FFFF0000);
    wait_idle("read");

    // back-to-back writes
    p0 = pops;
    exp_frame(41'h1_11_80000001, -1);
    exp_frame(41'h1_22_12345678, 3);
    push_tx(41'h1_11_80000001);
    push_tx(41'h1_22_12345678);
    wait_idle("b2b");
    chk("b2b_pops", pops - p0, 2);

    // RX full stall
    bus.rx_full = 1'b1;
    s_pat = {9'h155, 32'hA5A50FF0};
    exp_frame(41'h0_C3_00000000, -1);
    exp_rsp.push_back(40'hC3_A5A50FF0);
    push_tx(41'h0_C3_00000000);
    wait_cs(1'b0, "stall_start");
    wait_cs(1'b1, "stall_end");
    viol = 0;
    repeat (50) begin
      @(negedge rd_clk);
      if (!bus.busy || !bus.cs_n || bus.rx_wr_en) viol++;
    end
    chk("stall_viol", viol, 0);
    @(posedge rd_clk);
    #1 bus.rx_full = 1'b0;
    @(posedge rd_clk);
    #1 chk("push_after_release", bus.rx_wr_en, 1'b1);
    wait_idle("stall");

    // reset at rise 20 of a read; queued write runs cleanly
    s_pat = {9'h000, 32'h0BADF00D};
    exp_frame(41'h1_99_CAFEBABE, -1);
    push_tx(41'h0_77_00000000);
    push_tx(41'h1_99_CAFEBABE);
    rises = 0;
    c = 0;
    ps = 1'b0;
    while (rises < 20 && c < 3000) begin
      @(posedge rd_clk);
      #1;
      if (bus.sclk && !ps) rises++;
      ps = bus.sclk;
      c++;
    end
    if (c >= 3000) begin
      total++;
      bad++;
      $display("FAIL rise20 timeout rises=%0d", rises);
    end
    rd_rst_n = 1'b0;
    #1;
    chk("abort_sclk", bus.sclk, 1'b0);
    chk("abort_cs_n", bus.cs_n, 1'b1);
    chk("abort_mosi", bus.mosi, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    repeat (3) @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;
    wait_idle("after_abort");

    // enable high, FIFO empty
    viol = 0;
    repeat (100) begin
      @(negedge rd_clk);
      if (bus.tx_rd_en || !bus.cs_n) viol++;
    end
    chk("empty_idle_viol", viol, 0);

    // enable low, FIFO holding a word
    bus.enable = 1'b0;
    push_tx(41'h1_0F_F0F0F0F0);
    viol = 0;
    repeat (100) begin
      @(negedge rd_clk);
      if (bus.tx_rd_en || !bus.cs_n) viol++;
    end
    chk("disabled_viol", viol, 0);
    exp_frame(41'h1_0F_F0F0F0F0, -1);
    bus.enable = 1'b1;
    wait_idle("reenable");

    // enable dropped mid-frame
    exp_frame(41'h1_E1_13579BDF, -1);
    push_tx(41'h1_E1_13579BDF);
    push_tx(41'h1_E2_2468ACE0);
    wait_cs(1'b0, "midframe_start");
    bus.enable = 1'b0;
    wait_cs(1'b1, "midframe_end");
    viol = 0;
    repeat (100) begin
      @(negedge rd_clk);
      if (bus.tx_rd_en || !bus.cs_n) viol++;
    end
    chk("midframe_viol", viol, 0);
    chk("held_word", txq.size(), 1);
    exp_frame(41'h1_E2_2468ACE0, -1);
    bus.enable = 1'b1;
    wait_idle("flush");

    chk("frames_left", exp_frm.size(), 0);
    chk("rsp_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
